gg_mb_sequencer: RTL and testbench

Sequences one macroblock's 4x4 block jobs through the `gg_process` datapath in H.264 coding order. It issues cidx/bidx tags under an issue handshake and tracks them through the fixed-latency pipeline. It also produces the matching result tags and the strobes that advance the nc and dc_hold state flops. It sits between the macroblock-level controller (start/done) and the pixel-fetch/`gg_process`/bit-packer pipeline.

---
 rtl/gg_pkg.sv | 35 +++
 rtl/gg_job_order.sv | 48 ++++
 rtl/gg_mb_sequencer.sv | 168 ++++++++++++++++
 tb/tb_gg_mb_sequencer.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gg_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : gg_pkg                                                     |
// | Description : Shared types and constants for the macroblock sequencer:   |
// |               component-index enum, per-macroblock job counts and the    |
// |               block tag carried alongside each job.                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package gg_pkg;

   // Component index carried with every block job.
   typedef enum logic [2:0] {
      LUMA   = 3'd0,
      ACLUMA = 3'd1,
      CB     = 3'd2,
      CR     = 3'd3,
      DCCB   = 3'd4,
      DCCR   = 3'd5,
      DCY    = 3'd6
   } gg_cidx_e;

   // Jobs per macroblock (intra16x16 adds the luma DC job up front).
   localparam logic [4:0] MB_JOBS_I16 = 5'd27;
   localparam logic [4:0] MB_JOBS_N   = 5'd26;

   typedef struct packed {
      gg_cidx_e   cidx;
      logic [3:0] bidx;
      logic       last;
   } gg_tag_t;

   localparam int TAG_W = $bits(gg_tag_t);

endpackage
`default_nettype wire

// File: rtl/gg_job_order.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : gg_job_order                                               |
// | Description : Combinational map from (i16, sequence index) to the block  |
// |               tag in H.264 coding order.                                 |
// |   i_i16  in  1  intra16x16 macroblock                                    |
// |   i_seq  in  5  job sequence index                                       |
// |   o_tag  out    {cidx, bidx, last} for that job                          |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module gg_job_order
   import gg_pkg::*;
(
   input  logic       i_i16,
   input  logic [4:0] i_seq,
   output gg_tag_t    o_tag
);

   // Position within the common luma/dc/chroma order; in i16 mode the leading
   // DCY job shifts everything else up by one.
   logic [4:0] w_j;

   always_comb begin
      o_tag = '{cidx: LUMA, bidx: 4'd0, last: 1'b0};
      w_j   = i_i16 ? (i_seq - 5'd1) : i_seq;

      if (i_i16 && (i_seq == 5'd0)) begin
         o_tag.cidx = DCY;
      end else if (w_j < 5'd16) begin
         o_tag.cidx = i_i16 ? ACLUMA : LUMA;
         o_tag.bidx = w_j[3:0];
      end else if (w_j == 5'd16) begin
         o_tag.cidx = DCCB;
      end else if (w_j == 5'd17) begin
         o_tag.cidx = DCCR;
      end else if (w_j < 5'd22) begin
         o_tag.cidx = CB;
         o_tag.bidx = 4'(w_j - 5'd18);
      end else begin
         o_tag.cidx = CR;
         o_tag.bidx = 4'(w_j - 5'd22);
      end

      o_tag.last = (i_seq == (i_i16 ? (MB_JOBS_I16 - 5'd1) : (MB_JOBS_N - 5'd1)));
   end

endmodule
`default_nettype wire

// File: rtl/gg_mb_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : gg_mb_sequencer                                            |
// | Description : Issues one macroblock's 4x4 block jobs in coding order     |
// |               under a valid/ready handshake, tracks their tags through   |
// |               the fixed-latency datapath and emits result tags, state    |
// |               enables and the macroblock done/nc_update pulse.           |
// |   clk, reset (async, active-high)                                        |
// |   start, i16, abv/left_out_of_pic_in, abort       : controller side      |
// |   issue_valid/ready, issue_cidx/bidx               : job issue           |
// |   abv/left_out_of_pic                              : held edge flags     |
// |   res_valid/cidx/bidx/last, state_en, nc_update    : result side         |
// |   busy, done                                       : status              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module gg_mb_sequencer
   import gg_pkg::*;
#(
   parameter int PIPE_LAT = 2   // legal range 1..8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       i16,
   input  logic       abv_out_of_pic_in,
   input  logic       left_out_of_pic_in,
   input  logic       abort,
   input  logic       issue_ready,
   output logic       issue_valid,
   output logic [2:0] issue_cidx,
   output logic [3:0] issue_bidx,
   output logic       abv_out_of_pic,
   output logic       left_out_of_pic,
   output logic       res_valid,
   output logic [2:0] res_cidx,
   output logic [3:0] res_bidx,
   output logic       res_last,
   output logic       state_en,
   output logic       nc_update,
   output logic       busy,
   output logic       done
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   // One pipe stage is {valid, tag}; stage 0 sits in the low bits.
   localparam int STG_W  = TAG_W + 1;
   localparam int PIPE_W = PIPE_LAT * STG_W;

   logic [1:0]        state_q, state_d;
   logic [4:0]        seq_q,   seq_d;
   logic              i16_q,   i16_d;
   logic              abv_q,   abv_d;
   logic              left_q,  left_d;
   logic [PIPE_W-1:0] pipe_q,  pipe_d;

   gg_tag_t           w_tag;
   logic              w_xfer;
   logic [STG_W-1:0]  w_out;
   gg_tag_t           w_res_tag;
   logic              w_res_valid;
   logic              w_mb_done;

   gg_job_order u_job_order (
      .i_i16 (i16_q),
      .i_seq (seq_q),
      .o_tag (w_tag)
   );

   assign issue_valid = (state_q == ST_ISSUE);
   assign w_xfer      = issue_valid && issue_ready;
   assign issue_cidx  = issue_valid ? 3'(w_tag.cidx) : 3'd0;
   assign issue_bidx  = issue_valid ? w_tag.bidx : 4'd0;

   // Invalid stages are loaded with zeros, so the result tag reads 0 whenever
   // no result is present.
   assign w_out       = pipe_q[PIPE_W-1 -: STG_W];
   assign w_res_valid = w_out[STG_W-1];
   assign w_res_tag   = gg_tag_t'(w_out[TAG_W-1:0]);

   assign res_valid   = w_res_valid;
   assign res_cidx    = 3'(w_res_tag.cidx);
   assign res_bidx    = w_res_tag.bidx;
   assign res_last    = w_res_tag.last;
   assign state_en    = w_res_valid;

   // A flush in the same cycle as the final result suppresses completion.
   assign w_mb_done   = w_res_valid && w_res_tag.last && !abort;
   assign done        = w_mb_done;
   assign nc_update   = w_mb_done;

   assign busy            = (state_q != ST_IDLE);
   assign abv_out_of_pic  = abv_q;
   assign left_out_of_pic = left_q;

   // Tag pipe: shift every cycle, new stage 0 from the issue transfer; the
   // size cast drops the oldest stage.
   always_comb begin
      if (abort) begin
         pipe_d = '0;
      end else begin
         pipe_d = PIPE_W'({pipe_q, w_xfer, (w_xfer ? w_tag : gg_tag_t'('0))});
      end
   end

   always_comb begin
      state_d = state_q;
      seq_d   = seq_q;
      i16_d   = i16_q;
      abv_d   = abv_q;
      left_d  = left_q;

      if (abort) begin
         state_d = ST_IDLE;
         seq_d   = 5'd0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_d = ST_ISSUE;
                  seq_d   = 5'd0;
                  i16_d   = i16;
                  abv_d   = abv_out_of_pic_in;
                  left_d  = left_out_of_pic_in;
               end
            end
            ST_ISSUE: begin
               if (w_xfer) begin
                  if (w_tag.last) begin
                     state_d = ST_DRAIN;
                     seq_d   = 5'd0;
                  end else begin
                     seq_d = seq_q + 5'd1;
                  end
               end
            end
            ST_DRAIN: begin
               if (w_res_valid && w_res_tag.last) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         seq_q   <= 5'd0;
         i16_q   <= 1'b0;
         abv_q   <= 1'b0;
         left_q  <= 1'b0;
         pipe_q  <= '0;
      end else begin
         state_q <= state_d;
         seq_q   <= seq_d;
         i16_q   <= i16_d;
         abv_q   <= abv_d;
         left_q  <= left_d;
         pipe_q  <= pipe_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_gg_mb_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_gg_mb_sequencer                                         |
// | Description : Directed bench for gg_mb_sequencer. Two instances share    |
// |               the stimulus: index 0 has PIPE_LAT=2, index 1 PIPE_LAT=1.  |
// |               A cycle monitor compares every output against hand-written |
// |               job-order tables; directed checks pin key cycle numbers.   |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_gg_mb_sequencer;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0, i16 = 1'b0, abv_in = 1'b0, left_in = 1'b0;
   logic abort = 1'b0, issue_ready = 1'b0;

   logic       iv[2], ab[2], lf[2], rv[2], rl[2], se[2], nu[2], bz[2], dn[2];
   logic [2:0] ic[2], rc[2];
   logic [3:0] ib[2], rb[2];

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;
   bit mon_en = 1'b0;

   // Hand-written job order: cidx (0 luma,1 acluma,2 cb,3 cr,4 dccb,5 dccr,6 dcy).
   int tc0[27] = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0, 4,5, 2,2,2,2, 3,3,3,3, 0};
   int tb0[27] = '{0,1,2,3,4,5,6,7,8,9,10,11,12,13,14,15, 0,0, 0,1,2,3, 0,1,2,3, 0};
   int tc1[27] = '{6, 1,1,1,1,1,1,1,1,1,1,1,1,1,1,1,1, 4,5, 2,2,2,2, 3,3,3,3};
   int tb1[27] = '{0, 0,1,2,3,4,5,6,7,8,9,10,11,12,13,14,15, 0,0, 0,1,2,3, 0,1,2,3};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   gg_mb_sequencer #(.PIPE_LAT(2)) u_dut_lat2 (
      .clk(clk), .reset(reset), .start(start), .i16(i16),
      .abv_out_of_pic_in(abv_in), .left_out_of_pic_in(left_in),
      .abort(abort), .issue_ready(issue_ready),
      .issue_valid(iv[0]), .issue_cidx(ic[0]), .issue_bidx(ib[0]),
      .abv_out_of_pic(ab[0]), .left_out_of_pic(lf[0]),
      .res_valid(rv[0]), .res_cidx(rc[0]), .res_bidx(rb[0]), .res_last(rl[0]),
      .state_en(se[0]), .nc_update(nu[0]), .busy(bz[0]), .done(dn[0])
   );

   gg_mb_sequencer #(.PIPE_LAT(1)) u_dut_lat1 (
      .clk(clk), .reset(reset), .start(start), .i16(i16),
      .abv_out_of_pic_in(abv_in), .left_out_of_pic_in(left_in),
      .abort(abort), .issue_ready(issue_ready),
      .issue_valid(iv[1]), .issue_cidx(ic[1]), .issue_bidx(ib[1]),
      .abv_out_of_pic(ab[1]), .left_out_of_pic(lf[1]),
      .res_valid(rv[1]), .res_cidx(rc[1]), .res_bidx(rb[1]), .res_last(rl[1]),
      .state_en(se[1]), .nc_update(nu[1]), .busy(bz[1]), .done(dn[1])
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // ---------------- cycle monitor ----------------
   int  m_idx[2], ms, mlat, mlen, ec, eb;
   bit  m_iv[2], m_busy[2], m_i16[2], m_abv[2], m_left[2];
   bit  mdone, mwas;
   bit  sv[2][16], sl[2][16];
   int  sc[2][16], sb[2][16];

   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            for (int d = 0; d < 2; d++) begin
               m_iv[d] = 0; m_busy[d] = 0; m_idx[d] = 0;
               m_i16[d] = 0; m_abv[d] = 0; m_left[d] = 0;
               for (int s = 0; s < 16; s++) begin
                  sv[d][s] = 0; sl[d][s] = 0; sc[d][s] = 0; sb[d][s] = 0;
               end
            end
         end else if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
               ms   = cyc % 16;
               mlat = (d == 0) ? 2 : 1;
               ec   = 0;
               eb   = 0;
               chk($sformatf("d%0d_issue_valid", d), iv[d], m_iv[d]);
               if (m_iv[d]) begin
                  ec = m_i16[d] ? tc1[m_idx[d]] : tc0[m_idx[d]];
                  eb = m_i16[d] ? tb1[m_idx[d]] : tb0[m_idx[d]];
                  chk($sformatf("d%0d_issue_cidx", d), ic[d], ec);
                  chk($sformatf("d%0d_issue_bidx", d), ib[d], eb);
               end
               chk($sformatf("d%0d_busy", d), bz[d], m_busy[d]);
               chk($sformatf("d%0d_abv", d), ab[d], m_abv[d]);
               chk($sformatf("d%0d_left", d), lf[d], m_left[d]);
               chk($sformatf("d%0d_res_valid", d), rv[d], sv[d][ms]);
               chk($sformatf("d%0d_state_en", d), se[d], sv[d][ms]);
               chk($sformatf("d%0d_res_cidx", d), rc[d], sc[d][ms]);
               chk($sformatf("d%0d_res_bidx", d), rb[d], sb[d][ms]);
               chk($sformatf("d%0d_res_last", d), rl[d], sl[d][ms]);
               mdone = sv[d][ms] && sl[d][ms] && !abort;
               chk($sformatf("d%0d_done", d), dn[d], mdone);
               chk($sformatf("d%0d_nc_update", d), nu[d], mdone);
               sv[d][ms] = 0; sl[d][ms] = 0; sc[d][ms] = 0; sb[d][ms] = 0;

               mwas = m_busy[d];
               if (abort) begin
                  for (int s = 0; s < 16; s++) begin
                     sv[d][s] = 0; sl[d][s] = 0; sc[d][s] = 0; sb[d][s] = 0;
                  end
                  m_iv[d] = 0; m_idx[d] = 0; m_busy[d] = 0;
               end else begin
                  if (m_iv[d] && issue_ready) begin
                     mlen = m_i16[d] ? 27 : 26;
                     sv[d][(cyc + mlat) % 16] = 1;
                     sc[d][(cyc + mlat) % 16] = ec;
                     sb[d][(cyc + mlat) % 16] = eb;
                     sl[d][(cyc + mlat) % 16] = (m_idx[d] == mlen - 1);
                     if (m_idx[d] == mlen - 1) begin
                        m_iv[d] = 0; m_idx[d] = 0;
                     end else begin
                        m_idx[d]++;
                     end
                  end
                  if (mdone) m_busy[d] = 0;
                  if (!mwas && start) begin
                     m_busy[d] = 1; m_iv[d] = 1; m_idx[d] = 0;
                     m_i16[d] = i16; m_abv[d] = abv_in; m_left[d] = left_in;
                  end
               end
            end
         end
      end
   end

   // ---------------- directed stimulus ----------------
   int t0, d0, d1, nx0, nd0, nd1;

   initial begin
      // Reset state
      tick(2);
      @(negedge clk);
      for (int d = 0; d < 2; d++)
         chk($sformatf("d%0d_reset_outputs", d),
             {iv[d], rv[d], rl[d], se[d], nu[d], bz[d], dn[d], ab[d], lf[d],
              ic[d], ib[d], rc[d], rb[d]}, 0);
      tick(1);
      reset  = 1'b0;
      mon_en = 1'b1;

      // MB1: i16=0, ready=1; then back-to-back i16=1 starts at done+1 of each DUT
      tick(2);
      i16 = 1'b0; abv_in = 1'b1; left_in = 1'b0; issue_ready = 1'b1; start = 1'b1;
      t0 = cyc; d0 = -1; d1 = -1;
      for (int k = 1; k <= 29; k++) begin
         tick(1);
         start = (k >= 28);
         i16   = 1'b1;
         if (k >= 28) begin abv_in = 1'b0; left_in = 1'b1; end
         @(negedge clk);
         if (dn[0] && d0 < 0) d0 = cyc - t0;
         if (dn[1] && d1 < 0) d1 = cyc - t0;
         if (k == 29) chk("b2b_lat1_first_tag", {iv[1], ic[1], ib[1]}, {1'b1, 3'd6, 4'd0});
      end
      chk("mb1_done_cycle_lat2", d0, 28);
      chk("mb1_done_cycle_lat1", d1, 27);

      // MB2: i16=1 with ready toggling and a mid-macroblock start (i16=0)
      nx0 = 0; nd0 = 0; nd1 = 0;
      for (int k = 0; k < 80; k++) begin
         tick(1);
         issue_ready = (k % 2 == 0);
         start = (k == 10);
         i16   = (k == 10) ? 1'b0 : 1'b1;
         @(negedge clk);
         if (k == 0) chk("b2b_lat2_first_tag", {iv[0], ic[0], ib[0]}, {1'b1, 3'd6, 4'd0});
         if (iv[0] && issue_ready) nx0++;
         if (dn[0]) nd0++;
         if (dn[1]) nd1++;
      end
      chk("mb2_transfers_lat2", nx0, 27);
      chk("mb2_done_count_lat2", nd0, 1);
      chk("mb2_done_count_lat1", nd1, 1);

      // MB3: abort after the 10th transfer
      tick(1);
      i16 = 1'b0; issue_ready = 1'b1; start = 1'b1;
      for (int k = 1; k <= 11; k++) begin
         tick(1);
         start = 1'b0;
         abort = (k == 11);
      end
      tick(1);
      abort = 1'b0;
      @(negedge clk);
      chk("abort_next_cycle", {iv[0], rv[0], bz[0], iv[1], rv[1], bz[1]}, 0);
      nd0 = 0;
      for (int k = 0; k < 6; k++) begin
         tick(1);
         @(negedge clk);
         if (dn[0] || dn[1] || nu[0] || nu[1]) nd0++;
      end
      chk("abort_no_done", nd0, 0);

      // Fresh start after abort restarts at index 0
      tick(1);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      @(negedge clk);
      chk("restart_first_tag", {iv[0], ic[0], ib[0]}, {1'b1, 3'd0, 4'd0});
      nd0 = 0; nd1 = 0;
      for (int k = 0; k < 32; k++) begin
         tick(1);
         @(negedge clk);
         if (dn[0]) nd0++;
         if (dn[1]) nd1++;
      end
      chk("restart_done_lat2", nd0, 1);
      chk("restart_done_lat1", nd1, 1);

      // abort and start together in IDLE: abort wins
      tick(1);
      start = 1'b1; abort = 1'b1;
      tick(1);
      start = 1'b0; abort = 1'b0;
      @(negedge clk);
      chk("abort_beats_start", {bz[0], bz[1], iv[0], iv[1]}, 0);

      // Reset asserted while the PIPE_LAT=2 instance is in DRAIN
      tick(1);
      i16 = 1'b0; start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(26);
      #1 reset = 1'b1;
      #1;
      for (int d = 0; d < 2; d++)
         chk($sformatf("d%0d_async_reset_outputs", d),
             {iv[d], rv[d], rl[d], se[d], nu[d], bz[d], dn[d], ab[d], lf[d],
              ic[d], ib[d], rc[d], rb[d]}, 0);
      tick(2);
      reset = 1'b0;
      nd0 = 0;
      for (int k = 0; k < 40; k++) begin
         tick(1);
         @(negedge clk);
         if (dn[0] || dn[1] || bz[0] || bz[1]) nd0++;
      end
      chk("post_reset_quiet", nd0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
